// File: rtl/switch_debouncer_if.sv
// ---------------------------------------------------------------------------
// switch_debouncer_if
// Groups the switch-conditioning signals shared by the debouncer and its
// neighbours. The master side (switch source / bench) drives the raw
// levels. The slave side (the debouncer) returns the clean levels and the
// edge pulses.
//
// Signals:
//   sw_raw     [WIDTH]  raw asynchronous switch levels (master -> slave)
//   s_db       [WIDTH]  debounced switch levels        (slave -> master)
//   s_rise     [WIDTH]  one-cycle 0->1 event per bit   (slave -> master)
//   s_fall     [WIDTH]  one-cycle 1->0 event per bit   (slave -> master)
//   glitch_cnt [8]      saturating aborted-settle count, present only
//                       when GLITCH_COUNT_EN is defined
// ---------------------------------------------------------------------------
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] s_db;
  logic [WIDTH-1:0] s_rise;
  logic [WIDTH-1:0] s_fall;
`ifdef GLITCH_COUNT_EN
  logic [7:0]       glitch_cnt;

  modport master (output sw_raw, input s_db, input s_rise, input s_fall,
                  input glitch_cnt);
  modport slave  (input sw_raw, output s_db, output s_rise, output s_fall,
                  output glitch_cnt);
`else
  modport master (output sw_raw, input s_db, input s_rise, input s_fall);
  modport slave  (input sw_raw, output s_db, output s_rise, output s_fall);
`endif
endinterface

// File: rtl/switch_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
// Brings the raw DIP-switch levels into the clock domain through a
// two-flop synchroniser. It then debounces each bit on its own with a
// stability counter. An output bit only follows its input after the input
// has disagreed with it for DEBOUNCE_CYCLES consecutive synchronised
// cycles. Any return to agreement before that discards the partial count.
// Registered one-cycle rise/fall pulses accompany every output change.
//
// Ports:
//   clk    system clock (24 MHz)
//   reset  synchronous, active-low reset
//   dbIf   switch_debouncer_if.slave: sw_raw in; s_db, s_rise, s_fall out
//
// Optional feature macro: GLITCH_COUNT_EN
//   When defined, dbIf.glitch_cnt reports a saturating 8-bit count of
//   settles that were aborted before reaching terminal count.
// ---------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic              clk,
  input  logic              reset,
  switch_debouncer_if.slave dbIf
);

  // A bit flips on the edge where its counter already holds this value and
  // the mismatch is still present. With DEBOUNCE_CYCLES==1 the terminal
  // value is 0, so the STABLE state itself flips the bit on the first
  // mismatch.
  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
`ifdef GLITCH_COUNT_EN
  logic [WIDTH-1:0] abort;
  logic [7:0]       glitch_q;
  logic [7:0]       glitch_d;
  logic [8:0]       glitchSum;
`endif

  // Per-bit settling decision. A zero counter means STABLE and a non-zero
  // counter means SETTLING. On a mismatch the counter either advances or,
  // at terminal count, hands the new level to the output and restarts at
  // zero. A match always returns the bit to zero. If the bit was settling,
  // that return is an aborted settle (bounce).
  always_comb begin
    db_d  = db_q;
`ifdef GLITCH_COUNT_EN
    abort = '0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == TermCnt) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
`ifdef GLITCH_COUNT_EN
        abort[i] = (cnt_q[i] != '0);
`endif
      end
    end
  end

`ifdef GLITCH_COUNT_EN
  // Several bits may abort on the same edge, so add the whole population
  // count. Then clamp at 255 instead of wrapping.
  always_comb begin
    glitchSum = {1'b0, glitch_q} + 9'($countones(abort));
    glitch_d  = glitchSum[8] ? 8'hFF : glitchSum[7:0];
  end
`endif

  // State registers. Reset wins over everything, including a bit that is
  // part-way through settling. The edge pulses are derived from db_d so
  // that they appear in the same cycle as the new debounced level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef GLITCH_COUNT_EN
      glitch_q <= '0;
`endif
    end else begin
      sync1_q <= dbIf.sw_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      rise_q  <= db_d & ~db_q;
      fall_q  <= ~db_d & db_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef GLITCH_COUNT_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign dbIf.s_db   = db_q;
  assign dbIf.s_rise = rise_q;
  assign dbIf.s_fall = fall_q;
`ifdef GLITCH_COUNT_EN
  assign dbIf.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// ---------------------------------------------------------------------------
// tb_switch_debouncer
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES=8 and
// WIDTH=4. A table of per-cycle vectors covers:
//   - reset behaviour,
//   - clean steps,
//   - a short glitch,
//   - a bouncing input,
//   - a reset that lands mid-settle.
// Hand-written sequences then measure the step latency and the
// saturation of the glitch counter (GLITCH_COUNT_EN only).
// ---------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [3:0] db;
    logic [3:0] rise;
    logic [3:0] fall;
    int         glitch;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  switch_debouncer_if #(.WIDTH(WIDTH)) dbIf ();

  switch_debouncer #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dbIf(dbIf)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Append n identical rows to the table.
  // The glitch expectation is attached to the last row only;
  // -1 means no check.
  task automatic addRows(input logic r, input logic [3:0] sw,
                         input logic [3:0] db, input logic [3:0] rise,
                         input logic [3:0] fall, input int n,
                         input int glitch);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.rst    = r;
      v.sw     = sw;
      v.db     = db;
      v.rise   = rise;
      v.fall   = fall;
      v.glitch = (i == n - 1) ? glitch : -1;
      vecs.push_back(v);
    end
  endtask

  // One comparison: count it, and report it if it fails.
  task automatic checkVal(input string name, input int actual,
                          input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual,
               expected);
    end
  endtask

  // Drive inputs, then let the given number of clock edges pass.
  // Returns #1 after the last edge.
  task automatic applyStimulus(input logic r, input logic [3:0] sw,
                               input int cycles);
    reset       = r;
    dbIf.sw_raw = sw;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Compare all outputs against one table row.
  task automatic checkOutput(input int idx, input vec_t v);
    checkVal($sformatf("row%0d s_db", idx), int'(dbIf.s_db), int'(v.db));
    checkVal($sformatf("row%0d s_rise", idx), int'(dbIf.s_rise),
             int'(v.rise));
    checkVal($sformatf("row%0d s_fall", idx), int'(dbIf.s_fall),
             int'(v.fall));
`ifdef GLITCH_COUNT_EN
    if (v.glitch >= 0) begin
      checkVal($sformatf("row%0d glitch_cnt", idx), int'(dbIf.glitch_cnt),
               v.glitch);
    end
`endif
  endtask

  initial begin
    int  n;
    bit  done;
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    dbIf.sw_raw = 4'h0;

    // Reset held with switches high, then release: rise on the 10th
    // non-reset edge.
    addRows(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 3, 0);
    addRows(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 9, -1);
    addRows(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1, -1);
    addRows(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 3, 0);
    // Clean fall then clean rise on bit 0.
    addRows(1'b1, 4'hE, 4'hF, 4'h0, 4'h0, 9, -1);
    addRows(1'b1, 4'hE, 4'hE, 4'h0, 4'h1, 1, -1);
    addRows(1'b1, 4'hE, 4'hE, 4'h0, 4'h0, 2, 0);
    addRows(1'b1, 4'hF, 4'hE, 4'h0, 4'h0, 9, -1);
    addRows(1'b1, 4'hF, 4'hF, 4'h1, 4'h0, 1, -1);
    addRows(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 2, 0);
    // Three bits fall in parallel.
    addRows(1'b1, 4'h1, 4'hF, 4'h0, 4'h0, 9, -1);
    addRows(1'b1, 4'h1, 4'h1, 4'h0, 4'hE, 1, -1);
    addRows(1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 2, 0);
    // Seven-cycle glitch on bit 1: no change, one aborted settle.
    addRows(1'b1, 4'h3, 4'h1, 4'h0, 4'h0, 7, -1);
    addRows(1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 12, 1);
    // Bit 2 rises cleanly, then bounces low three times before staying low.
    addRows(1'b1, 4'h5, 4'h1, 4'h0, 4'h0, 9, -1);
    addRows(1'b1, 4'h5, 4'h5, 4'h4, 4'h0, 1, -1);
    addRows(1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 2, 1);
    for (int b = 0; b < 3; b++) begin
      addRows(1'b1, 4'h1, 4'h5, 4'h0, 4'h0, 3, -1);
      addRows(1'b1, 4'h5, 4'h5, 4'h0, 4'h0, 3, -1);
    end
    addRows(1'b1, 4'h1, 4'h5, 4'h0, 4'h0, 9, -1);
    addRows(1'b1, 4'h1, 4'h1, 4'h0, 4'h4, 1, -1);
    addRows(1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 2, 4);
    // Reset when bit 3's counter has reached 5; the full delay is needed
    // again afterwards.
    addRows(1'b1, 4'h9, 4'h1, 4'h0, 4'h0, 7, -1);
    addRows(1'b0, 4'h9, 4'h0, 4'h0, 4'h0, 1, 0);
    addRows(1'b1, 4'h9, 4'h0, 4'h0, 4'h0, 9, -1);
    addRows(1'b1, 4'h9, 4'h9, 4'h9, 4'h0, 1, -1);
    addRows(1'b1, 4'h9, 4'h9, 4'h0, 4'h0, 2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].sw, 1);
      checkOutput(i, vecs[i]);
    end

    // Step latency on bit 2: the new level is visible after the 10th edge,
    // counting the edge that first samples the step.
    reset       = 1'b1;
    dbIf.sw_raw = 4'hD;
    n    = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (dbIf.s_db[2]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL latency timeout: s_db=0x%0h, expected 0xd",
               dbIf.s_db);
    end else begin
      checkVal("latency edges", n, DEB + 2);
      checkVal("latency s_rise", int'(dbIf.s_rise), 4);
      applyStimulus(1'b1, 4'hD, 1);
      checkVal("latency s_rise clears", int'(dbIf.s_rise), 0);
      checkVal("latency s_db hold", int'(dbIf.s_db), 'hD);
    end

`ifdef GLITCH_COUNT_EN
    // Many 3-cycle glitches on bit 1: count tracks them, then saturates.
    for (int g = 0; g < 300; g++) begin
      applyStimulus(1'b1, 4'hF, 3);
      applyStimulus(1'b1, 4'hD, 3);
      if (g == 99) checkVal("glitch_cnt at 100", int'(dbIf.glitch_cnt), 100);
    end
    applyStimulus(1'b1, 4'hD, 10);
    checkVal("glitch_cnt saturated", int'(dbIf.glitch_cnt), 255);
    checkVal("s_db after glitches", int'(dbIf.s_db), 'hD);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
